// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_bus_pkg
// Brief    : Shared types and constants for the unified memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

  // Default bus widths used by the interface and the arbiter
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Arbiter state encoding
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Master identifiers, also used as the grant id
  localparam logic MASTER_CPU    = 1'b0;
  localparam logic MASTER_LOADER = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_port_arbiter_if
// Brief     : Bundles both requester handshakes and the memory strobe bus.
//             The slave modport is the arbiter view; the master modport is
//             the view of the requesters and memory that surround it.
// Revision  : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Master 0 (control unit)
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_resp;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;

  // Master 1 (program loader / debug)
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_resp;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;

  // Memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_response;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_resp, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_resp, m1_err, m1_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_response
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_resp, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_resp, m1_err, m1_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_response
  );

endinterface
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : mem_timeout_counter
// Brief    : Saturating cycle counter that flags expiry when the count
//            reaches limit-1. A limit of zero never expires.
// Revision : 1.0 - initial release
// ============================================================================
module mem_timeout_counter #(
  parameter int CNT_W = 8
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             clear,
  input  wire logic             enable,
  input  wire logic [CNT_W-1:0] limit,
  output logic                  expired
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise count up and hold at all-ones
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // Count register, cleared asynchronously by the active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (limit != '0) && (count_q == (limit - CNT_ONE));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one memory port between the control
//            unit (master 0) and the loader (master 1), with a bounded
//            timeout that completes a stalled access with an error.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic         clock,
  input  wire logic         reset,
  mem_port_arbiter_if.slave bus
);

  // Wide enough to hold TIMEOUT_CYCLES; a disabled timeout still needs 1 bit
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e        state_q,      state_d;
  logic              grant_q,      grant_d;
  logic              last_grant_q, last_grant_d;
  logic              dir_q,        dir_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic              m0_resp_q,    m0_resp_d;
  logic              m0_err_q,     m0_err_d;
  logic [DATA_W-1:0] m0_rdata_q,   m0_rdata_d;
  logic              m1_resp_q,    m1_resp_d;
  logic              m1_err_q,     m1_err_d;
  logic [DATA_W-1:0] m1_rdata_q,   m1_rdata_d;

  logic m0_elig;
  logic m1_elig;
  logic sel;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;

  mem_timeout_counter #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .limit   (TIMEOUT_LIMIT),
    .expired (cnt_expired)
  );

  assign cnt_enable = (state_q == BUSY);

  // Arbitration and completion: grant in IDLE, finish or time out in BUSY
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    dir_d        = dir_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m0_resp_d    = 1'b0;
    m0_err_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_resp_d    = 1'b0;
    m1_err_d     = 1'b0;
    m1_rdata_d   = m1_rdata_q;
    cnt_clear    = 1'b0;
    sel          = MASTER_CPU;
    // A master whose resp is high this cycle has not yet dropped req
    m0_elig      = bus.m0_req && !m0_resp_q;
    m1_elig      = bus.m1_req && !m1_resp_q;

    case (state_q)
      IDLE: begin
        if (m0_elig || m1_elig) begin
          if (m0_elig && m1_elig) begin
            sel = ~last_grant_q;
          end else begin
            sel = m1_elig ? MASTER_LOADER : MASTER_CPU;
          end
          grant_d      = sel;
          last_grant_d = sel;
          state_d      = BUSY;
          cnt_clear    = 1'b1;
          if (sel == MASTER_LOADER) begin
            addr_d  = bus.m1_addr;
            wdata_d = bus.m1_wdata;
            dir_d   = bus.m1_we;
          end else begin
            addr_d  = bus.m0_addr;
            wdata_d = bus.m0_wdata;
            dir_d   = bus.m0_we;
          end
        end
      end
      BUSY: begin
        if (bus.mem_response) begin
          state_d = IDLE;
          if (grant_q == MASTER_LOADER) begin
            m1_resp_d = 1'b1;
            if (!dir_q) m1_rdata_d = bus.mem_rdata;
          end else begin
            m0_resp_d = 1'b1;
            if (!dir_q) m0_rdata_d = bus.mem_rdata;
          end
        end else if (cnt_expired) begin
          state_d = IDLE;
          if (grant_q == MASTER_LOADER) begin
            m1_resp_d  = 1'b1;
            m1_err_d   = 1'b1;
            m1_rdata_d = '0;
          end else begin
            m0_resp_d  = 1'b1;
            m0_err_d   = 1'b1;
            m0_rdata_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered responses; reset drops everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= MASTER_CPU;
      last_grant_q <= MASTER_LOADER;
      dir_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_resp_q    <= 1'b0;
      m0_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_resp_q    <= 1'b0;
      m1_err_q     <= 1'b0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      dir_q        <= dir_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_resp_q    <= m0_resp_d;
      m0_err_q     <= m0_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_resp_q    <= m1_resp_d;
      m1_err_q     <= m1_err_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Strobes decode straight from registered state so reset clears them at once
  assign bus.mem_read  = (state_q == BUSY) && !dir_q;
  assign bus.mem_write = (state_q == BUSY) &&  dir_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.m0_resp   = m0_resp_q;
  assign bus.m0_err    = m0_err_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_resp   = m1_resp_q;
  assign bus.m1_err    = m1_err_q;
  assign bus.m1_rdata  = m1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter. Expected memory accesses
//            and responses are queued as stimulus is issued; a negedge
//            monitor pops and compares whenever a strobe rises or a resp
//            pulse appears. A small memory model answers after a set delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model knobs: response after resp_delay strobe cycles (0 = never)
  int          resp_delay = 2;
  logic [31:0] rd_base    = 32'h0;
  logic        idle_noise = 1'b0;
  int          mem_scnt   = 0;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } mem_t;

  resp_t resp_q[$];
  mem_t  mem_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [31:0] wd, input int len);
    mem_t m;
    m.we = we; m.addr = a; m.wdata = wd; m.len = len;
    mem_q.push_back(m);
  endtask

  task automatic exp_resp(input int id, input logic err, input logic [31:0] rd);
    resp_t r;
    r.id = id; r.err = err; r.rdata = rd;
    resp_q.push_back(r);
  endtask

  task automatic set_req(input int id, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
    if (id == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = wd;
    end
  endtask

  task automatic wait_resp(input int id);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if ((id == 0) ? bus.m0_resp : bus.m1_resp) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout_m%0d: got no resp in 60 cycles, required one", id);
    end
  endtask

  task automatic run_master(input int id, input logic we, input logic [31:0] a0, input logic [31:0] wd0);
    for (int k = 0; k < 4; k++) begin
      set_req(id, 1'b1, we, a0 + 32'(4 * k), wd0 + 32'(k));
      wait_resp(id);
    end
    set_req(id, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Memory model: answers the current strobe after resp_delay cycles
  initial begin
    bus.mem_response = 1'b0;
    bus.mem_rdata    = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) begin
        mem_scnt++;
        if (resp_delay != 0 && mem_scnt == resp_delay) begin
          bus.mem_response = 1'b1;
          bus.mem_rdata    = bus.mem_write ? 32'hBAD0BAD0 : (rd_base ^ bus.mem_addr);
        end else begin
          bus.mem_response = 1'b0;
          bus.mem_rdata    = 32'hBAD0BAD0;
        end
      end else begin
        mem_scnt         = 0;
        bus.mem_response = idle_noise;
        bus.mem_rdata    = 32'hBAD0BAD0;
      end
    end
  end

  // Monitor: compares memory accesses and responses against the queues
  logic  prev_strobe = 1'b0;
  logic  mon_strobe;
  mem_t  cur;
  resp_t mon_r;
  int    mon_id;
  int    slen = 0;

  always @(negedge clk) begin
    mon_strobe = bus.mem_read | bus.mem_write;
    if (rst_n) begin
      if (mon_strobe && !prev_strobe) begin
        if (mem_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mem_unexpected: got access at 0x%08h, required none", bus.mem_addr);
          cur.we = bus.mem_write; cur.addr = bus.mem_addr; cur.wdata = bus.mem_wdata; cur.len = -1;
        end else begin
          cur = mem_q.pop_front();
          chk("mem_dir", {31'b0, bus.mem_write}, {31'b0, cur.we});
        end
        slen = 0;
      end
      if (mon_strobe) begin
        slen++;
        chk("strobe_excl", {31'b0, bus.mem_read & bus.mem_write}, 32'h0);
        chk("mem_addr", bus.mem_addr, cur.addr);
        chk("mem_wdata", bus.mem_wdata, cur.wdata);
      end
      if (!mon_strobe && prev_strobe && cur.len >= 0) begin
        chk("strobe_len", slen, cur.len);
      end
      if (bus.m0_resp || bus.m1_resp) begin
        chk("resp_excl", {31'b0, bus.m0_resp & bus.m1_resp}, 32'h0);
        chk("resp_timing", {30'b0, prev_strobe, mon_strobe}, 32'h2);
        if (resp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: got m0_resp=%0b m1_resp=%0b, required none",
                   bus.m0_resp, bus.m1_resp);
        end else begin
          mon_r  = resp_q.pop_front();
          mon_id = bus.m1_resp ? 1 : 0;
          chk("resp_master", mon_id, mon_r.id);
          chk("resp_err", {31'b0, (mon_id == 1) ? bus.m1_err : bus.m0_err}, {31'b0, mon_r.err});
          chk("resp_rdata", (mon_id == 1) ? bus.m1_rdata : bus.m0_rdata, mon_r.rdata);
        end
      end
    end
    prev_strobe = mon_strobe;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, required earlier end");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ctrl_outputs", {26'b0, bus.m0_resp, bus.m0_err, bus.m1_resp, bus.m1_err,
                             bus.mem_read, bus.mem_write}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
    chk("rst_m1_rdata", bus.m1_rdata, 32'h0);
    rst_n = 1'b1;

    // Test 1: m0 read of 0x100, memory answers on the third strobe cycle
    @(negedge clk);
    resp_delay = 3;
    rd_base    = 32'hDEADBFEF;
    exp_mem(1'b0, 32'h100, 32'h55, 3);
    exp_resp(0, 1'b0, 32'hDEADBEEF);
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h55);
    @(negedge clk);
    chk("t1_strobe_latency", {31'b0, bus.mem_read}, 32'h1);
    wait_resp(0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_resp_one_cycle", {31'b0, bus.m0_resp}, 32'h0);
    chk("t1_rdata_hold", bus.m0_rdata, 32'hDEADBEEF);

    // Test 2: fresh reset, both masters write in the same cycle; m0 first
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_noise = 1'b1;
    resp_delay = 2;
    exp_mem(1'b1, 32'h10, 32'h11110000, 2);
    exp_resp(0, 1'b0, 32'h0);
    exp_mem(1'b1, 32'h20, 32'h22220000, 2);
    exp_resp(1, 1'b0, 32'h0);
    fork
      begin
        set_req(0, 1'b1, 1'b1, 32'h10, 32'h11110000);
        wait_resp(0);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      begin
        set_req(1, 1'b1, 1'b1, 32'h20, 32'h22220000);
        wait_resp(1);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    join

    // Test 3: both masters request back to back; grants alternate 0,1,0,1
    @(negedge clk);
    rd_base = 32'h0;
    exp_mem(1'b0, 32'h300, 32'h50, 2); exp_resp(0, 1'b0, 32'h300);
    exp_mem(1'b1, 32'h400, 32'hA0, 2); exp_resp(1, 1'b0, 32'h0);
    exp_mem(1'b0, 32'h304, 32'h51, 2); exp_resp(0, 1'b0, 32'h304);
    exp_mem(1'b1, 32'h404, 32'hA1, 2); exp_resp(1, 1'b0, 32'h0);
    exp_mem(1'b0, 32'h308, 32'h52, 2); exp_resp(0, 1'b0, 32'h308);
    exp_mem(1'b1, 32'h408, 32'hA2, 2); exp_resp(1, 1'b0, 32'h0);
    exp_mem(1'b0, 32'h30C, 32'h53, 2); exp_resp(0, 1'b0, 32'h30C);
    exp_mem(1'b1, 32'h40C, 32'hA3, 2); exp_resp(1, 1'b0, 32'h0);
    fork
      run_master(0, 1'b0, 32'h300, 32'h50);
      run_master(1, 1'b1, 32'h400, 32'hA0);
    join

    // Test 4: m1 read loads rdata, then a stalled read times out after 8 cycles
    @(negedge clk);
    idle_noise = 1'b0;
    resp_delay = 1;
    exp_mem(1'b0, 32'h504, 32'h0, 1);
    exp_resp(1, 1'b0, 32'h504);
    set_req(1, 1'b1, 1'b0, 32'h504, 32'h0);
    wait_resp(1);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    resp_delay = 0;
    exp_mem(1'b0, 32'h500, 32'h0, 8);
    exp_resp(1, 1'b1, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h500, 32'h0);
    wait_resp(1);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t4_strobes_idle", {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
    resp_delay = 1;
    exp_mem(1'b0, 32'h600, 32'h0, 1);
    exp_resp(0, 1'b0, 32'h600);
    set_req(0, 1'b1, 1'b0, 32'h600, 32'h0);
    wait_resp(0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Test 5: reset in the middle of a transaction
    @(negedge clk);
    resp_delay = 0;
    exp_mem(1'b0, 32'h700, 32'h0, -1);
    set_req(0, 1'b1, 1'b0, 32'h700, 32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_strobes_async", {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
    chk("t5_resp_async", {30'b0, bus.m0_resp, bus.m1_resp}, 32'h0);
    chk("t5_mem_addr_async", bus.mem_addr, 32'h0);
    chk("t5_m0_rdata_async", bus.m0_rdata, 32'h0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    resp_delay = 2;
    exp_mem(1'b0, 32'h710, 32'h0, 2);
    exp_resp(0, 1'b0, 32'h710);
    set_req(0, 1'b1, 1'b0, 32'h710, 32'h0);
    wait_resp(0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Test 6: m0 inputs change one cycle after grant; latched values hold
    @(negedge clk);
    resp_delay = 4;
    exp_mem(1'b1, 32'h40, 32'h40, 4);
    exp_resp(0, 1'b0, 32'h710);
    set_req(0, 1'b1, 1'b1, 32'h40, 32'h40);
    @(negedge clk);
    bus.m0_addr  = 32'h80;
    bus.m0_wdata = 32'h80;
    wait_resp(0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    chk("resp_q_drained", resp_q.size(), 32'h0);
    chk("mem_q_drained", mem_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters: master 0 (control unit: fetch, load and store) and master 1 (program loader / debug port).
- Each transaction is a req/resp handshake. The arbiter latches address, data and direction, drives the memory strobes, and waits for mem_response.
- A bounded timeout returns an error response.
- Sits between the control unit/loader and the memory model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, cycles in BUSY without mem_response before an error response; 0 disables the timeout

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request; held until m0_resp
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_resp  out  1  one-cycle completion pulse for master 0
- m0_err  out  1  timeout flag, valid with m0_resp
- m0_rdata  out  DATA_W  read data, valid with m0_resp
- m1_req, m1_we, m1_addr, m1_wdata, m1_resp, m1_err, m1_rdata: same as the m0_* ports, for master 1
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_response
- mem_response  in  1  memory completion

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=1, timeout count=0.
  - All outputs 0, including mX_resp, mX_err, mX_rdata, mem_read, mem_write, mem_addr, mem_wdata.
  - Reset mid-transaction abandons it; no resp is issued.
- States: IDLE, BUSY. Grant id (1 bit) is registered alongside the state.
- IDLE:
  - Eligible request = mX_req && !mX_resp. A requester is ignored in the cycle its resp pulse is high, which prevents a double grant before it drops req.
  - Only one eligible: grant it.
  - Both eligible: grant the master that is not last_grant (round-robin).
  - On the grant edge: latch addr, wdata and we into mem_addr/mem_wdata/dir; set grant and last_grant; count=0; go to BUSY.
  - No eligible request: stay in IDLE.
- BUSY:
  - mem_read = !dir, mem_write = dir, both combinational from state. Exactly one strobe is high; both are low in IDLE.
  - Edge with mem_response=1:
    - go to IDLE;
    - pulse resp of the granted master for one cycle, err=0;
    - rdata register = mem_rdata on reads, held unchanged on writes.
  - Else, if TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1:
    - go to IDLE;
    - resp=1, err=1, rdata=0.
  - Else count+1. The count saturates and never wraps.
  - mem_response in IDLE is ignored.
- Latency:
  - req sampled at edge N → strobe visible in cycle N+1.
  - mem_response at edge M → resp high in cycle M+1.
  - Minimum 1 IDLE cycle between transactions.
- Inputs mX_addr/wdata/we may change after grant with no effect until the next grant.
- mX_rdata holds its value until the next read completes for that master.
- mX_resp pulses are mutually exclusive.

Decomposition:
- Package mem_bus_pkg holds:
  - state encoding (IDLE=0, BUSY=1);
  - master id constants (MASTER_CPU=0, MASTER_LOADER=1);
  - default ADDR_W/DATA_W.
- One natural sub-module: mem_timeout_counter, with inputs clear, enable and limit, and output expired. It saturates and supports the limit-0 disable.

Test Plan:
1. Reset, then m0 read of addr 0x100 with mem_response 3 cycles after the strobe and mem_rdata=0xDEADBEEF → mem_read high for 3 cycles, mem_addr=0x100; m0_resp one cycle, m0_rdata=0xDEADBEEF, m0_err=0.
2. m0_req and m1_req raised in the same cycle after reset, each a write → m0 served first (last_grant=1 at reset), then m1 after one IDLE cycle; mem_wdata matches each master; exactly one resp per master.
3. Both masters request continuously, 4 transactions each → grants alternate 0,1,0,1…; neither is starved; no back-to-back double grant to the master whose resp is high.
4. TIMEOUT_CYCLES=8, mem_response held at 0 → m1_resp=1, m1_err=1, m1_rdata=0 exactly 8 cycles after the strobe rises; strobes drop; state returns to IDLE.
5. Reset asserted mid-BUSY → strobes drop immediately (asynchronous); no resp pulse; first request after reset release is granted normally.
6. m0_addr changed from 0x40 to 0x80 one cycle after grant → mem_addr stays 0x40 for the whole transaction.
